// File: rtl/merge_sort_stream.sv
// merge_sort_stream
//   Streaming block-merge sorter. Each accepted beat of four signed words is
//   sorted combinationally and stored as one row of a group (NUM_BLK rows).
//   A completed group drains one word per cycle through a NUM_BLK-way merge,
//   in descending or ascending order. Two ping-pong banks let one group fill
//   while the previous one drains.
//
//   Optional build macro: MERGE_SORT_FLUSH_EN adds the flush input, which
//   closes a partial group.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   in_valid    input beat valid
//   in_ready    block can accept a beat
//   in_descend  group order, latched on row 0 (1 = descending)
//   in_d0..3    four signed words of a beat
//   flush       (MERGE_SORT_FLUSH_EN only) close the current partial group
//   out_valid   out_data valid
//   out_ready   consumer accepts out_data
//   out_data    merged word, signed
//   out_last    final word of a group
module merge_sort_stream #(
  parameter int DATA_W  = 8,
  parameter int NUM_BLK = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_descend,
  input  logic signed [DATA_W-1:0] in_d0,
  input  logic signed [DATA_W-1:0] in_d1,
  input  logic signed [DATA_W-1:0] in_d2,
  input  logic signed [DATA_W-1:0] in_d3,
`ifdef MERGE_SORT_FLUSH_EN
  input  logic                     flush,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last
);

  localparam int GRP_LEN = 4 * NUM_BLK;
  localparam int CW      = $clog2(NUM_BLK);
  localparam int TW      = $clog2(GRP_LEN) + 1;

  typedef enum logic {IDLE, MERGE} state_t;

  function automatic logic signed [DATA_W-1:0] smin(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a < b) ? b : a;
  endfunction

  logic signed [DATA_W-1:0] mem [2][NUM_BLK][4];
  logic                     full_q [2];
  logic                     desc_q [2];
  logic [CW:0]              rows_used_q [2];
  logic                     wr_bank, rd_bank;
  logic [CW-1:0]            wr_cnt;
  logic [2:0]               head_q [NUM_BLK];
  logic [TW-1:0]            emit_cnt;
  state_t                   state_q, state_d;

  logic                     accept, flush_in, close, step, drain_done, can_load;
  logic [CW:0]              close_rows;
  logic [TW-1:0]            total_words;
  logic                     desc_p0;
  logic signed [DATA_W-1:0] m0, m1, m2, m3, lo, hi, x, y, mlo, mhi;
  logic signed [DATA_W-1:0] asc [4];
  logic signed [DATA_W-1:0] srt_p0 [4];
  logic                     sel_found;
  logic [CW-1:0]            sel_row;
  logic signed [DATA_W-1:0] sel_data, cand;

  assign in_ready = !full_q[wr_bank];
  assign accept   = in_valid && in_ready;

`ifdef MERGE_SORT_FLUSH_EN
  assign flush_in = flush && in_ready;
`else
  assign flush_in = 1'b0;
`endif

  // A flush without a beat on an empty group closes nothing.
  assign close      = accept ? ((wr_cnt == CW'(NUM_BLK - 1)) || flush_in)
                             : (flush_in && (wr_cnt != '0));
  assign close_rows = accept ? ({1'b0, wr_cnt} + (CW+1)'(1)) : {1'b0, wr_cnt};

  // ---- stage p0: 5-comparator sort of the incoming beat ----
  always_comb begin
    m0  = smin(in_d0, in_d1);
    m1  = smax(in_d0, in_d1);
    m2  = smin(in_d2, in_d3);
    m3  = smax(in_d2, in_d3);
    lo  = smin(m0, m2);
    x   = smax(m0, m2);
    y   = smin(m1, m3);
    hi  = smax(m1, m3);
    mlo = smin(x, y);
    mhi = smax(x, y);
    asc = '{lo, mlo, mhi, hi};
    // Row 0 supplies the group's order; later rows reuse the latched bit.
    desc_p0 = (wr_cnt == '0) ? in_descend : desc_q[wr_bank];
    for (int k = 0; k < 4; k++)
      srt_p0[k] = desc_p0 ? asc[3-k] : asc[k];
  end

  // Stored rows are in merge order, so head 0 is always the row's best word.
  always_ff @(posedge clk) begin
    if (accept)
      for (int k = 0; k < 4; k++)
        mem[wr_bank][wr_cnt][k] <= srt_p0[k];
  end

  // ---- merge select: best head over live rows, lowest index wins ties ----
  always_comb begin
    sel_found = 1'b0;
    sel_row   = '0;
    sel_data  = '0;
    cand      = '0;
    for (int r = 0; r < NUM_BLK; r++) begin
      if ((r < int'(rows_used_q[rd_bank])) && (head_q[r] != 3'd4)) begin
        cand = mem[rd_bank][r][head_q[r][1:0]];
        if (!sel_found || (desc_q[rd_bank] ? (cand > sel_data) : (cand < sel_data))) begin
          sel_found = 1'b1;
          sel_row   = CW'(r);
          sel_data  = cand;
        end
      end
    end
  end

  assign total_words = TW'({rows_used_q[rd_bank], 2'b00});
  assign drain_done  = out_valid && out_ready && out_last;
  assign can_load    = !out_valid || out_ready;

  // The first step may fire while still IDLE so the first word appears one
  // edge after the group fills.
  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank]) begin
          state_d = MERGE;
          step    = can_load && sel_found;
        end
      end
      MERGE: begin
        if (drain_done) state_d = IDLE;
        else            step    = can_load && sel_found;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- output register and bank control ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      full_q    <= '{1'b0, 1'b0};
      desc_q    <= '{1'b0, 1'b0};
      rows_used_q <= '{'0, '0};
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      emit_cnt  <= '0;
      for (int r = 0; r < NUM_BLK; r++) head_q[r] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept && (wr_cnt == '0)) desc_q[wr_bank] <= in_descend;
      if (close) begin
        full_q[wr_bank]      <= 1'b1;
        rows_used_q[wr_bank] <= close_rows;
        wr_bank              <= ~wr_bank;
        wr_cnt               <= '0;
      end else if (accept) begin
        wr_cnt <= wr_cnt + CW'(1);
      end

      if (step) begin
        out_valid        <= 1'b1;
        out_data         <= sel_data;
        out_last         <= (emit_cnt == total_words - TW'(1));
        head_q[sel_row]  <= head_q[sel_row] + 3'd1;
        emit_cnt         <= emit_cnt + TW'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Close and drain always touch different banks, so both may apply.
      if (drain_done) begin
        full_q[rd_bank] <= 1'b0;
        rd_bank         <= ~rd_bank;
        emit_cnt        <= '0;
        for (int r = 0; r < NUM_BLK; r++) head_q[r] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_merge_sort_stream.sv
module tb_merge_sort_stream;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic                    in_descend = 1'b0;
  logic signed [7:0]       in_d0 = '0, in_d1 = '0, in_d2 = '0, in_d3 = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [7:0]       out_data;
  logic                    out_last;
`ifdef MERGE_SORT_FLUSH_EN
  logic                    flush_i = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;
  int got_q[$];
  int last_q[$];
  int row_q[$];
  int exp_q[$];
  int rdy_mode = 0;
  int ph = 0;
  logic hold_pend = 1'b0;
  int held_d = 0;
  int held_l = 0;

  merge_sort_stream #(.DATA_W(8), .NUM_BLK(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_descend(in_descend),
    .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2), .in_d3(in_d3),
`ifdef MERGE_SORT_FLUSH_EN
    .flush(flush_i),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // out_ready: held high, or the repeating pattern 1,0,0.
  always @(posedge clk) begin
    #1;
    if (rdy_mode != 0) begin
      out_ready = (ph == 0);
      ph = (ph == 2) ? 0 : ph + 1;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Output collector, stall-stability monitor and drained-row recorder.
  always @(negedge clk) begin
    if (rst) begin
      if (hold_pend) begin
        check_eq("hold_data", int'(out_data), held_d);
        check_eq("hold_last", int'(out_last), held_l);
      end
      if (out_valid && out_ready) begin
        got_q.push_back(int'(out_data));
        last_q.push_back(int'(out_last));
      end
      if (dut.step) row_q.push_back(int'(dut.sel_row));
      hold_pend = out_valid && !out_ready;
      held_d = int'(out_data);
      held_l = int'(out_last);
    end else begin
      hold_pend = 1'b0;
    end
  end

  // Called in the posedge+1 phase; returns in the same phase after the accept edge.
  task automatic send_beat(input int a, input int b, input int c, input int d, input logic desc);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_d0 = 8'(a); in_d1 = 8'(b); in_d2 = 8'(c); in_d3 = 8'(d);
    in_descend = desc;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check_eq("beat_accept", 0, 1);
  endtask

  task automatic wait_words(input int n);
    int c;
    c = 0;
    while (got_q.size() < n && c < 600) begin
      @(negedge clk);
      #1;
      c++;
    end
    repeat (4) @(negedge clk);
    check_eq("word_count", got_q.size(), n);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_range(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      if (base + i < got_q.size()) begin
        check_eq($sformatf("word[%0d]", base + i), got_q[base + i], exp_q[base + i]);
        check_eq($sformatf("last[%0d]", base + i), last_q[base + i], (i == n - 1) ? 1 : 0);
      end
    end
  endtask

  task automatic clear_all();
    got_q.delete();
    last_q.delete();
    row_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_data", int'(out_data), 0);
    check_eq("rst_out_last", int'(out_last), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", int'(in_ready), 1);

    // Descending group, rows {0..3}..{28..31}.
    clear_all();
    for (int r = 0; r < 8; r++) send_beat(4*r, 4*r+1, 4*r+2, 4*r+3, 1'b1);
    @(posedge clk);
    #1;
    check_eq("first_valid", int'(out_valid), 1);
    check_eq("first_data", int'(out_data), 31);
    for (int i = 0; i < 32; i++) exp_q.push_back(31 - i);
    wait_words(32);
    compare_range(0, 32);

    // Ascending group, same data.
    clear_all();
    for (int r = 0; r < 8; r++) send_beat(4*r, 4*r+1, 4*r+2, 4*r+3, 1'b0);
    for (int i = 0; i < 32; i++) exp_q.push_back(i);
    wait_words(32);
    compare_range(0, 32);

    // All words equal: rows must drain in index order.
    clear_all();
    for (int r = 0; r < 8; r++) send_beat(5, 5, 5, 5, 1'b1);
    for (int i = 0; i < 32; i++) exp_q.push_back(5);
    wait_words(32);
    compare_range(0, 32);
    check_eq("tie_row_count", row_q.size(), 32);
    for (int i = 0; i < 32; i++)
      if (i < row_q.size()) check_eq($sformatf("tie_row[%0d]", i), row_q[i], i / 4);

    // Two back-to-back groups under 1,0,0 backpressure.
    clear_all();
    rdy_mode = 1;
    for (int r = 0; r < 8; r++) send_beat(4*r, 4*r+1, 4*r+2, 4*r+3, 1'b1);
    for (int r = 0; r < 8; r++) send_beat(43+4*r, 40+4*r, 42+4*r, 41+4*r, 1'b0);
    check_eq("both_full_in_ready", int'(in_ready), 0);
    for (int i = 0; i < 32; i++) exp_q.push_back(31 - i);
    for (int i = 0; i < 32; i++) exp_q.push_back(40 + i);
    wait_words(64);
    compare_range(0, 32);
    compare_range(32, 32);
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Reset in the middle of a drain.
    clear_all();
    for (int r = 0; r < 8; r++) send_beat(4*r, 4*r+1, 4*r+2, 4*r+3, 1'b1);
    c = 0;
    while (got_q.size() < 10 && c < 200) begin
      @(negedge clk);
      #1;
      c++;
    end
    check_eq("pre_reset_words", got_q.size(), 10);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_in_ready", int'(in_ready), 1);
    check_eq("post_rst_out_valid", int'(out_valid), 0);

    // Fresh ascending group with signed extremes.
    clear_all();
    send_beat(127, -128, 0, -1, 1'b0);
    for (int r = 1; r < 8; r++) send_beat(4*r-1, 4*r-3, 4*r, 4*r-2, 1'b0);
    exp_q.push_back(-128);
    exp_q.push_back(-1);
    exp_q.push_back(0);
    for (int i = 1; i <= 28; i++) exp_q.push_back(i);
    exp_q.push_back(127);
    wait_words(32);
    compare_range(0, 32);

`ifdef MERGE_SORT_FLUSH_EN
    // Partial group closed by a lone flush.
    clear_all();
    send_beat(9, 1, 4, 7, 1'b1);
    send_beat(2, 8, 3, 6, 1'b1);
    send_beat(5, 0, 11, 10, 1'b1);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    for (int i = 0; i < 12; i++) exp_q.push_back(11 - i);
    wait_words(12);
    compare_range(0, 12);

    // Flush on an empty group produces nothing.
    clear_all();
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("empty_flush_words", got_q.size(), 0);
    check_eq("empty_flush_valid", int'(out_valid), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
